// File: rtl/multiplier8_arbiter.sv
// Round-robin front end sharing one multiplier8 between NREQ clients; sequences the
// multiplier's operand-write / strobe / ready protocol and returns one response at a time.
//
// state     | meaning
// IDLE      | search req_valid from the round-robin pointer
// LOAD_A    | operand A on the write bus (write=01)
// LOAD_B    | operand B on the write bus (write=10)
// SETTLE    | write=00 held so the multiplier's registered write clears
// STROBE    | single-cycle start pulse
// WAIT_BUSY | wait for mul_ready to drop, bounded by TIMEOUT
// WAIT_DONE | wait for mul_ready to rise, bounded by TIMEOUT
// RESPOND   | response held until rsp_ready
module multiplier8_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int TIMEOUT     = 15
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*8-1:0]        req_a,
  input  logic [NREQ*8-1:0]        req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [15:0]              rsp_result,
  output logic                     rsp_error,
  output logic                     mul_enable,
  output logic [1:0]               mul_write,
  output logic [7:0]               mul_operand,
  output logic                     mul_strobe,
  input  logic [15:0]              mul_result,
  input  logic                     mul_ready
);

  localparam int IW   = $clog2(NREQ);
  localparam int SW   = IW + 1;
  localparam int TMAX = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_A    = 3'd1;
  localparam logic [2:0] S_LOAD_B    = 3'd2;
  localparam logic [2:0] S_SETTLE    = 3'd3;
  localparam logic [2:0] S_STROBE    = 3'd4;
  localparam logic [2:0] S_WAIT_BUSY = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = 3'd6;
  localparam logic [2:0] S_RESPOND   = 3'd7;

  logic [2:0]    state;
  logic [TW-1:0] tmr;
  logic          tmr_done;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] cur_id;
  logic          found;
  logic [SW-1:0] sum;
  logic [7:0]    op_a;
  logic [7:0]    op_b;
  logic [15:0]   result_q;
  logic          error_q;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      if (!found && req_valid[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

  assign tmr_done = (tmr == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      tmr       <= '0;
      ptr       <= '0;
      cur_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
      req_ready <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        S_IDLE: if (found) begin
          req_ready[win] <= 1'b1;
          op_a     <= req_a[{win, 3'b000} +: 8];
          op_b     <= req_b[{win, 3'b000} +: 8];
          cur_id   <= win;
          ptr      <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
          result_q <= '0;
          error_q  <= 1'b0;
          tmr      <= HOLD_LOAD;
          state    <= S_LOAD_A;
        end
        S_LOAD_A, S_LOAD_B, S_SETTLE: begin
          if (tmr_done) begin
            tmr   <= HOLD_LOAD;
            state <= (state == S_LOAD_A) ? S_LOAD_B :
                     (state == S_LOAD_B) ? S_SETTLE : S_STROBE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_STROBE: begin
          tmr   <= TO_LOAD;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!mul_ready) begin
            tmr   <= TO_LOAD;
            state <= S_WAIT_DONE;
          end else if (tmr_done) begin
            error_q  <= 1'b1;
            result_q <= '0;
            state    <= S_RESPOND;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (mul_ready) begin
            result_q <= mul_result;
            state    <= S_RESPOND;
          end else if (tmr_done) begin
            error_q  <= 1'b1;
            result_q <= '0;
            state    <= S_RESPOND;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_RESPOND: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mul_write   = 2'b00;
    mul_operand = 8'h00;
    case (state)
      S_LOAD_A: begin
        mul_write   = 2'b01;
        mul_operand = op_a;
      end
      S_LOAD_B: begin
        mul_write   = 2'b10;
        mul_operand = op_b;
      end
      S_SETTLE: mul_operand = op_b;
      default: ;
    endcase
  end

  assign mul_enable = (state != S_IDLE) && (state != S_RESPOND);
  assign mul_strobe = (state == S_STROBE);
  assign rsp_valid  = (state == S_RESPOND);
  assign rsp_id     = cur_id;
  assign rsp_result = result_q;
  assign rsp_error  = error_q;

endmodule
